// File: rtl/uart_tx.sv
// UART transmit engine: start bit, MSB data bits LSB first, optional parity, one stop bit.
// Each bit is held for CLKS_PER_BIT clocks. All outputs are registered.
module uart_tx #(
    parameter int MSB          = 8,
    parameter int CLKS_PER_BIT = 8,
    parameter int PARITY       = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [MSB-1:0] data,
    input  logic           send,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic           tx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(MSB + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(MSB - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [MSB-1:0] shift_q, shift_d;
    logic           par_q, par_d;
    logic           tx_q, tx_d;
    logic           ready_q, ready_d;
    logic           done_q, done_d;

    logic bit_end;
    logic accept;

    assign bit_end = (cnt_q == CNT_LAST);
    // ready_q is only high in IDLE or the final stop cycle, so it gates acceptance alone.
    assign accept  = send && ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A held send is taken on the final stop cycle, so frames run back-to-back.
        if (accept) begin
            state_d = S_START;
            shift_d = data;
            par_d   = (PARITY == 2) ? ~(^data) : ^data;
            cnt_d   = '0;
            idx_d   = '0;
        end

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            S_PAR:   tx_d = par_d;
            default: tx_d = 1'b1;
        endcase

        ready_d = (state_d == S_IDLE) || ((state_d == S_STOP) && (cnt_d == CNT_LAST));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = ~ready_q;
    assign done  = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no, even, odd parity) with MSB=8, CLKS_PER_BIT=4.
module tb_uart_tx;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data = 8'h00;
    logic       send_r [3];
    logic       tx_w [3];
    logic       ready_w [3];
    logic       busy_w [3];
    logic       done_w [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx #(.MSB(8), .CLKS_PER_BIT(C), .PARITY(0)) u_dut0 (
        .clk(clk), .reset(reset), .data(data), .send(send_r[0]),
        .ready(ready_w[0]), .busy(busy_w[0]), .done(done_w[0]), .tx(tx_w[0]));
    uart_tx #(.MSB(8), .CLKS_PER_BIT(C), .PARITY(1)) u_dut1 (
        .clk(clk), .reset(reset), .data(data), .send(send_r[1]),
        .ready(ready_w[1]), .busy(busy_w[1]), .done(done_w[1]), .tx(tx_w[1]));
    uart_tx #(.MSB(8), .CLKS_PER_BIT(C), .PARITY(2)) u_dut2 (
        .clk(clk), .reset(reset), .data(data), .send(send_r[2]),
        .ready(ready_w[2]), .busy(busy_w[2]), .done(done_w[2]), .tx(tx_w[2]));

    typedef struct {
        int          sel;
        logic [7:0]  d;
        logic [10:0] bits;  // bit i is the i-th line bit, start bit first
        int          nb;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input int sel, input logic [7:0] d, input logic [10:0] bits,
                             input int nb, input int poke_at, input string tag);
        int f;
        int bad_tx;
        int bad_done;
        int bad_busy;
        f = nb * C;
        bad_tx = 0;
        bad_done = 0;
        bad_busy = 0;
        @(negedge clk);
        check({tag, "_ready_before"}, 32'(ready_w[sel]), 32'd1);
        data = d;
        send_r[sel] = 1'b1;
        @(posedge clk);
        #1;
        send_r[sel] = 1'b0;
        data = ~d;
        for (int m = 0; m < f; m++) begin
            @(negedge clk);
            if (tx_w[sel] !== bits[m / C]) bad_tx++;
            if (done_w[sel] !== 1'b0) bad_done++;
            if (m < f - 1 && busy_w[sel] !== 1'b1) bad_busy++;
            if (m == poke_at) begin
                data = 8'hFF;
                send_r[sel] = 1'b1;
            end else begin
                send_r[sel] = 1'b0;
            end
        end
        check({tag, "_tx_bits_errors"}, 32'(bad_tx), 32'd0);
        check({tag, "_early_done"}, 32'(bad_done), 32'd0);
        check({tag, "_busy_errors"}, 32'(bad_busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done_w[sel]), 32'd1);
        check({tag, "_ready_after"}, 32'(ready_w[sel]), 32'd1);
        check({tag, "_tx_idle"}, 32'(tx_w[sel]), 32'd1);
        @(negedge clk);
        check({tag, "_done_single"}, 32'(done_w[sel]), 32'd0);
    endtask

    initial begin
        int bad;
        int ndone;
        int d1;
        int d2;
        logic [9:0] exp55;
        logic [9:0] expaa;
        logic       e;

        for (int i = 0; i < 3; i++) send_r[i] = 1'b0;

        vecs[0] = '{0, 8'hA5, {1'b0, 1'b1, 8'hA5, 1'b0}, 10};
        vecs[1] = '{1, 8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 11};
        vecs[2] = '{2, 8'hA5, {1'b1, 1'b1, 8'hA5, 1'b0}, 11};
        vecs[3] = '{1, 8'h01, {1'b1, 1'b1, 8'h01, 1'b0}, 11};
        vecs[4] = '{0, 8'h00, {1'b0, 1'b1, 8'h00, 1'b0}, 10};
        vecs[5] = '{0, 8'hFF, {1'b0, 1'b1, 8'hFF, 1'b0}, 10};
        vecs[6] = '{2, 8'h00, {1'b1, 1'b1, 8'h00, 1'b0}, 11};
        vecs[7] = '{1, 8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}, 11};

        // Reset and idle
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int m = 0; m < 50; m++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                if (tx_w[s] !== 1'b1 || ready_w[s] !== 1'b1 || busy_w[s] !== 1'b0 ||
                    done_w[s] !== 1'b0) bad++;
            end
        end
        check("reset_idle_errors", 32'(bad), 32'd0);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].sel, vecs[i].d, vecs[i].bits, vecs[i].nb, -1,
                      $sformatf("vec%0d", i));
        end

        // send while busy is ignored
        run_frame(0, 8'h3C, {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 15, "busy_ignore");
        bad = 0;
        ndone = 0;
        for (int m = 0; m < 80; m++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) bad++;
            if (done_w[0] === 1'b1) ndone++;
        end
        check("busy_ignore_no_second_frame", 32'(bad), 32'd0);
        check("busy_ignore_no_extra_done", 32'(ndone), 32'd0);

        // Back-to-back with send held high
        exp55 = {1'b1, 8'h55, 1'b0};
        expaa = {1'b1, 8'hAA, 1'b0};
        bad = 0;
        ndone = 0;
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        data = 8'h55;
        send_r[0] = 1'b1;
        @(posedge clk);
        #1;
        data = 8'hAA;
        for (int m = 0; m <= 80; m++) begin
            @(negedge clk);
            if (m < 80) begin
                e = (m < 40) ? exp55[m / C] : expaa[(m - 40) / C];
                if (tx_w[0] !== e) bad++;
            end
            if (done_w[0] === 1'b1) begin
                ndone++;
                if (d1 < 0) d1 = m;
                else d2 = m;
            end
            if (m == 40) send_r[0] = 1'b0;
        end
        check("b2b_tx_bits_errors", 32'(bad), 32'd0);
        check("b2b_done_count", 32'(ndone), 32'd2);
        check("b2b_first_done_at", 32'(d1), 32'd40);
        check("b2b_done_spacing", 32'(d2 - d1), 32'd40);
        bad = 0;
        ndone = 0;
        for (int m = 0; m < 40; m++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) bad++;
            if (done_w[0] === 1'b1) ndone++;
        end
        check("b2b_no_third_frame", 32'(bad), 32'd0);
        check("b2b_no_third_done", 32'(ndone), 32'd0);

        // Reset during data bit 3 (cycles 16..19 after acceptance)
        @(negedge clk);
        data = 8'h3C;
        send_r[0] = 1'b1;
        @(posedge clk);
        #1;
        send_r[0] = 1'b0;
        for (int m = 0; m <= 17; m++) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_tx", 32'(tx_w[0]), 32'd1);
        check("midreset_ready", 32'(ready_w[0]), 32'd1);
        check("midreset_busy", 32'(busy_w[0]), 32'd0);
        check("midreset_done", 32'(done_w[0]), 32'd0);
        bad = 0;
        ndone = 0;
        for (int m = 0; m < 60; m++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) bad++;
            if (done_w[0] === 1'b1) ndone++;
        end
        check("midreset_line_idle", 32'(bad), 32'd0);
        check("midreset_no_done", 32'(ndone), 32'd0);
        run_frame(0, 8'h81, {1'b0, 1'b1, 8'h81, 1'b0}, 10, -1, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
